// File: rtl/cdpga_hd_uart.sv
`default_nettype none
// ============================================================================
// Module   : cdpga_hd_uart
// Brief    : Half-duplex UART/RS485 line controller: framed RX with start-bit
//            validation, carrier-sensed TX FIFO with tx_en guard times.
//            Define CDPGA_HD_UART_PARITY_EN to add one even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module cdpga_hd_uart #(
    parameter int DIV        = 139,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int IDLE_BITS  = 10,
    parameter int TX_PRE     = 1,
    parameter int TX_POST    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx,
    output logic                 tx,
    output logic                 tx_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_err,
    output logic                 bus_idle
);

`ifdef CDPGA_HD_UART_PARITY_EN
    localparam int c_PAR_BITS = 1;
`else
    localparam int c_PAR_BITS = 0;
`endif
    // Bits carried between the start and stop bits
    localparam int c_FRAME_BITS = DATA_BITS + c_PAR_BITS;
    localparam int c_CW         = $clog2(DIV);
    localparam int c_AW         = $clog2(FIFO_DEPTH);
    localparam int c_IDLE_MAX   = IDLE_BITS * DIV;
    localparam int c_IW         = $clog2(c_IDLE_MAX + 1);
    localparam int c_BMAX0      = (c_FRAME_BITS > TX_PRE) ? c_FRAME_BITS : TX_PRE;
    localparam int c_BMAX       = (c_BMAX0 > TX_POST) ? c_BMAX0 : TX_POST;
    localparam int c_BW         = $clog2(c_BMAX + 1);

    localparam logic [c_CW-1:0] c_DIV_M1   = c_CW'(DIV - 1);
    localparam logic [c_CW-1:0] c_HALF     = c_CW'(DIV / 2);
    localparam logic [c_IW-1:0] c_IDLE_TOP = c_IW'(c_IDLE_MAX);
    localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(c_FRAME_BITS - 1);

    // ---------------- input synchroniser and idle detector ----------------
    logic            r_rx_meta, r_rxs, r_rxs_d;
    logic [c_IW-1:0] r_idle_cnt;
    logic [c_IW-1:0] w_idle_next;
    logic            r_bus_idle;
    logic            w_rx_fall;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
        end
    end

    assign w_rx_fall   = r_rxs_d & ~r_rxs;
    assign w_idle_next = !r_rxs ? '0 :
                         (r_idle_cnt == c_IDLE_TOP) ? r_idle_cnt : r_idle_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_idle_cnt <= '0;
            r_bus_idle <= 1'b0;
        end else begin
            r_idle_cnt <= w_idle_next;
            r_bus_idle <= (w_idle_next == c_IDLE_TOP);
        end
    end

    assign bus_idle = r_bus_idle;

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {S_RX_IDLE, S_RX_START, S_RX_DATA, S_RX_STOP} rx_state_t;
    rx_state_t               r_rx_state, w_rx_state_next;
    logic [c_CW-1:0]         r_rx_cnt;
    logic [c_BW-1:0]         r_rx_bits;
    logic [c_FRAME_BITS-1:0] r_rx_shift;
    logic [DATA_BITS-1:0]    r_rx_data;
    logic                    r_rx_valid, r_rx_err;
    logic                    w_rx_done, w_rx_par_ok;

`ifdef CDPGA_HD_UART_PARITY_EN
    assign w_rx_par_ok = ~^r_rx_shift;
`else
    assign w_rx_par_ok = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_rx_state <= S_RX_IDLE;
        else          r_rx_state <= w_rx_state_next;
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_done       = 1'b0;
        case (r_rx_state)
            S_RX_IDLE:  if (w_rx_fall) w_rx_state_next = S_RX_START;
            // A line that is high again at mid start bit was only a glitch
            S_RX_START: if (r_rx_cnt == '0) w_rx_state_next = r_rxs ? S_RX_IDLE : S_RX_DATA;
            S_RX_DATA:  if (r_rx_cnt == '0 && r_rx_bits == c_LAST_BIT) w_rx_state_next = S_RX_STOP;
            S_RX_STOP: begin
                if (r_rx_cnt == '0) begin
                    w_rx_state_next = S_RX_IDLE;
                    w_rx_done       = 1'b1;
                end
            end
            default:    w_rx_state_next = S_RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            if (r_rx_state == S_RX_IDLE) begin
                r_rx_cnt  <= c_HALF;
                r_rx_bits <= '0;
            end else if (r_rx_cnt == '0) begin
                r_rx_cnt <= c_DIV_M1;
                if (r_rx_state == S_RX_DATA) begin
                    r_rx_shift <= {r_rxs, r_rx_shift[c_FRAME_BITS-1:1]};
                    r_rx_bits  <= r_rx_bits + 1'b1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt - 1'b1;
            end
            if (w_rx_done) begin
                if (r_rxs && w_rx_par_ok) begin
                    r_rx_data  <= r_rx_shift[DATA_BITS-1:0];
                    r_rx_valid <= 1'b1;
                end else begin
                    r_rx_err <= 1'b1;
                end
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_err   = r_rx_err;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]        r_wr_ptr, r_rd_ptr;
    logic                 w_empty, w_full, w_push, w_pop;
    logic [DATA_BITS-1:0] w_head;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push   = tx_valid && !w_full;
    assign tx_ready = !w_full;
    assign w_head   = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {
        S_TX_IDLE, S_TX_PRE, S_TX_START, S_TX_DATA, S_TX_STOP, S_TX_POST
    } tx_state_t;
    tx_state_t               r_tx_state, w_tx_state_next;
    logic [c_CW-1:0]         r_tx_cnt;
    logic [c_BW-1:0]         r_tx_bits;
    logic [c_FRAME_BITS-1:0] r_tx_shift;
    logic [c_FRAME_BITS-1:0] w_tx_frame;
    logic                    w_tx_tick;

`ifdef CDPGA_HD_UART_PARITY_EN
    assign w_tx_frame = {^w_head, w_head};
`else
    assign w_tx_frame = w_head;
`endif

    assign w_tx_tick = (r_tx_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_tx_state <= S_TX_IDLE;
        else          r_tx_state <= w_tx_state_next;
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            S_TX_IDLE:
                if (!w_empty && r_bus_idle)
                    w_tx_state_next = (TX_PRE > 0) ? S_TX_PRE : S_TX_START;
            S_TX_PRE:
                if (w_tx_tick && int'(r_tx_bits) == TX_PRE - 1) w_tx_state_next = S_TX_START;
            S_TX_START:
                if (w_tx_tick) w_tx_state_next = S_TX_DATA;
            S_TX_DATA:
                if (w_tx_tick && r_tx_bits == c_LAST_BIT) w_tx_state_next = S_TX_STOP;
            // Queued bytes follow immediately without re-checking the carrier
            S_TX_STOP:
                if (w_tx_tick)
                    w_tx_state_next = !w_empty ? S_TX_START :
                                      (TX_POST > 0) ? S_TX_POST : S_TX_IDLE;
            S_TX_POST:
                if (w_tx_tick && int'(r_tx_bits) == TX_POST - 1) w_tx_state_next = S_TX_IDLE;
            default:
                w_tx_state_next = S_TX_IDLE;
        endcase
        w_pop = (w_tx_state_next == S_TX_START) && (r_tx_state != S_TX_START);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_shift <= '0;
        end else begin
            if (w_tx_state_next != r_tx_state) begin
                r_tx_cnt  <= c_DIV_M1;
                r_tx_bits <= '0;
            end else if (w_tx_tick) begin
                r_tx_cnt  <= c_DIV_M1;
                r_tx_bits <= r_tx_bits + 1'b1;
                if (r_tx_state == S_TX_DATA) r_tx_shift <= r_tx_shift >> 1;
            end else begin
                r_tx_cnt <= r_tx_cnt - 1'b1;
            end
            if (w_pop) r_tx_shift <= w_tx_frame;
        end
    end

    always_comb begin
        tx    = 1'b1;
        tx_en = (r_tx_state != S_TX_IDLE);
        case (r_tx_state)
            S_TX_START: tx = 1'b0;
            S_TX_DATA:  tx = r_tx_shift[0];
            default:    tx = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cdpga_hd_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdpga_hd_uart
// Brief    : Self-checking bench for cdpga_hd_uart: loopback, framing error,
//            glitch, carrier sense, FIFO overflow and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdpga_hd_uart;
    localparam int DIV        = 8;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int IDLE_BITS  = 2;
    localparam int TX_PRE     = 1;
    localparam int TX_POST    = 1;
`ifdef CDPGA_HD_UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_CYC = (DATA_BITS + 2 + PAR) * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx, tx, tx_en, tx_valid, tx_ready, rx_valid, rx_err, bus_idle;
    logic [7:0] tx_data, rx_data;
    logic       loop_en, rx_drive;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         n_err = 0;
    int         n_both = 0;

    assign rx = loop_en ? tx : rx_drive;

    always #5 clk = ~clk;

    cdpga_hd_uart #(
        .DIV(DIV), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH),
        .IDLE_BITS(IDLE_BITS), .TX_PRE(TX_PRE), .TX_POST(TX_POST)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .rx(rx), .tx(tx), .tx_en(tx_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .bus_idle(bus_idle)
    );

    // Receive-side scoreboard capture
    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (rx_err) n_err++;
        if (rx_valid && rx_err) n_both++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level of bit i of a frame: start, data LSB first, [parity], stop
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= DATA_BITS) return b[i-1];
        if (PAR == 1 && i == DATA_BITS + 1) return ^b;
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(output int lat);
        lat = 0;
        while (!bus_idle && lat < 200) begin
            tick();
            lat++;
        end
        chk("bus_idle_wait", bus_idle, 1);
    endtask

    task automatic wait_txen(output int lat);
        lat = 0;
        while (!tx_en && lat < 400) begin
            tick();
            lat++;
        end
        chk("tx_en_wait", tx_en, 1);
    endtask

    // Entered on the first cycle tx_en is seen high; checks every cycle of the burst
    task automatic check_burst(input string tag);
        int n;
        int total;
        int r;
        logic e;
        n     = exp_q.size();
        total = TX_PRE * DIV + n * FRAME_CYC + TX_POST * DIV;
        for (int k = 0; k < total; k++) begin
            if (k < TX_PRE * DIV || k >= TX_PRE * DIV + n * FRAME_CYC) begin
                e = 1'b1;
            end else begin
                r = k - TX_PRE * DIV;
                e = frame_bit(exp_q[r / FRAME_CYC], (r % FRAME_CYC) / DIV);
            end
            chk({tag, "_tx"}, tx, e);
            chk({tag, "_tx_en"}, tx_en, 1);
            tick();
        end
        chk({tag, "_tx_en_end"}, tx_en, 0);
        chk({tag, "_tx_end"}, tx, 1);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_rx_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            chk({tag, "_rx_byte"}, rx_q[i], exp_q[i]);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        for (int i = 0; i <= DATA_BITS + PAR; i++) begin
            rx_drive = frame_bit(b, i);
            repeat (DIV) tick();
        end
        rx_drive = stop;
        repeat (DIV) tick();
        rx_drive = 1'b1;
    endtask

    // Hold the bus busy, queue n bytes, then release and expect one burst
    task automatic busy_send(input int n, input string tag);
        int level;
        int lat;
        logic [7:0] b;
        logic seen_en;
        level   = 0;
        seen_en = 1'b0;
        loop_en = 1'b0;
        rx_drive = 1'b0;
        exp_q.delete();
        repeat (4) tick();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (level < FIFO_DEPTH) begin
                exp_q.push_back(b);
                level++;
            end
            push(b);
            chk({tag, "_tx_ready"}, tx_ready, (level < FIFO_DEPTH) ? 1 : 0);
        end
        repeat (120) begin
            tick();
            if (tx_en) seen_en = 1'b1;
        end
        chk({tag, "_held_off"}, seen_en, 0);
        rx_q.delete();
        loop_en = 1'b1;
        wait_txen(lat);
        chk({tag, "_idle_gap"}, lat >= IDLE_BITS * DIV, 1);
        if (tx_en) check_burst(tag);
        repeat (4) tick();
        check_rx(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int err0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic seen_en;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        loop_en  = 1'b0;
        rx_drive = 1'b1;
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_bus_idle", bus_idle, 0);

        // Loopback of a single byte with guard times
        rst_n   = 1'b1;
        loop_en = 1'b1;
        wait_idle(lat);
        chk("idle_after_reset", (lat >= IDLE_BITS * DIV) && (lat <= IDLE_BITS * DIV + 2), 1);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        rx_q.delete();
        push(8'hA5);
        wait_txen(lat);
        if (tx_en) check_burst("a5");
        repeat (4) tick();
        check_rx("a5");

        // Externally driven good frame, then one with a low stop bit
        loop_en = 1'b0;
        rx_drive = 1'b1;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        rx_q.delete();
        drive_frame(b1, 1'b1);
        repeat (4) tick();
        exp_q.delete();
        exp_q.push_back(b1);
        check_rx("ext_good");
        err0 = n_err;
        rx_q.delete();
        drive_frame(b2, 1'b0);
        repeat (6) tick();
        chk("stop_err_pulses", n_err - err0, 1);
        chk("stop_err_no_valid", rx_q.size(), 0);
        chk("stop_err_rx_data_kept", rx_data, b1);

        // Two-cycle glitch while idle
        wait_idle(lat);
        err0 = n_err;
        rx_q.delete();
        rx_drive = 1'b0;
        repeat (2) tick();
        rx_drive = 1'b1;
        repeat (4) tick();
        chk("glitch_bus_idle_drop", bus_idle, 0);
        wait_idle(lat);
        chk("glitch_idle_recover", lat + 4 >= IDLE_BITS * DIV, 1);
        repeat (4) tick();
        chk("glitch_no_valid", rx_q.size(), 0);
        chk("glitch_no_err", n_err - err0, 0);

        // Carrier sense and FIFO overflow
        busy_send(3, "busy3");
        busy_send(5, "full5");

        // Reset in the middle of a data bit
        wait_idle(lat);
        for (int i = 0; i < 3; i++) push(8'($urandom));
        wait_txen(lat);
        repeat (TX_PRE * DIV + DIV + 3 * DIV) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_tx_en", tx_en, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_bus_idle", bus_idle, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_q.delete();
        seen_en = 1'b0;
        repeat (IDLE_BITS * DIV + 80) begin
            tick();
            if (tx_en) seen_en = 1'b1;
        end
        chk("post_rst_no_frame", seen_en, 0);
        chk("post_rst_bus_idle", bus_idle, 1);
        chk("post_rst_no_rx", rx_q.size(), 0);
        chk("valid_err_exclusive", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
